// File: rtl/bin_gray_pipe.sv
// Streaming binary-to-Gray encoder with a two-stage valid/ready pipeline.
// Stage 1 registers the binary word and stage 2 registers its Gray code.
// The output side tracks Gray adjacency between consecutive transfers and
// keeps a saturating count of non-adjacent transfers.
module bin_gray_pipe #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_gray,
   output logic             out_adj,
   output logic [7:0]       adj_err_cnt
);

   localparam int POP_W = $clog2(WIDTH + 1);

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_bin_q, s1_bin_d;
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] s2_gray_q, s2_gray_d;
   logic             prev_valid_q, prev_valid_d;
   logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
   logic [7:0]       err_cnt_q, err_cnt_d;

   logic             s2_free;
   logic             s1_adv;
   logic             in_xfer;
   logic             out_xfer;
   logic [WIDTH-1:0] diff;
   logic [POP_W-1:0] pop;
   logic             adj;

   // Handshake: in_ready looks through s2 so a full pipe can still accept
   // a word on the same edge that the output drains.
   always_comb begin
      s2_free  = !s2_valid_q || out_ready;
      s1_adv   = s1_valid_q && s2_free;
      in_ready = !s1_valid_q || s2_free;
      in_xfer  = in_valid && in_ready;
      out_xfer = s2_valid_q && out_ready;
   end

   // Stage 1 next state: load on input transfer, empty when it advances.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_bin_d   = s1_bin_q;
      if (in_xfer) begin
         s1_valid_d = 1'b1;
         s1_bin_d   = in_bin;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end
   end

   // Stage 2 next state: encode on advance, empty on an unrefilled transfer.
   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_gray_d  = s2_gray_q;
      if (s1_adv) begin
         s2_valid_d = 1'b1;
         s2_gray_d  = s1_bin_q ^ (s1_bin_q >> 1);
      end else if (out_xfer) begin
         s2_valid_d = 1'b0;
      end
   end

   // Adjacency: exactly one bit differs from the last transferred code.
   always_comb begin
      diff = s2_gray_q ^ prev_gray_q;
      pop  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pop = pop + POP_W'(diff[i]);
      end
      adj = s2_valid_q && prev_valid_q && (pop == POP_W'(1));
   end

   // History and error count update on each output transfer.
   always_comb begin
      prev_valid_d = prev_valid_q;
      prev_gray_d  = prev_gray_q;
      err_cnt_d    = err_cnt_q;
      if (out_xfer) begin
         prev_valid_d = 1'b1;
         prev_gray_d  = s2_gray_q;
         if (prev_valid_q && !adj && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
      end
   end

   // State registers; reset wipes in-flight words and adjacency history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_bin_q     <= '0;
         s2_valid_q   <= 1'b0;
         s2_gray_q    <= '0;
         prev_valid_q <= 1'b0;
         prev_gray_q  <= '0;
         err_cnt_q    <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_bin_q     <= s1_bin_d;
         s2_valid_q   <= s2_valid_d;
         s2_gray_q    <= s2_gray_d;
         prev_valid_q <= prev_valid_d;
         prev_gray_q  <= prev_gray_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   // Outputs come straight from registers apart from the adjacency compare.
   always_comb begin
      out_valid   = s2_valid_q;
      out_gray    = s2_gray_q;
      out_adj     = adj;
      adj_err_cnt = err_cnt_q;
   end

endmodule

// File: tb/tb_bin_gray_pipe.sv
module tb_bin_gray_pipe;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_bin = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] out_gray;
   logic       out_adj;
   logic [7:0] adj_err_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [3:0] bin;
      logic [3:0] gray;
      logic       adj;
   } vec_t;

   vec_t vecs[19];

   logic [3:0] cap_gray[$];
   logic       cap_adj[$];
   logic [3:0] sent_q[$];

   bin_gray_pipe #(.WIDTH(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_bin      (in_bin),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_gray    (out_gray),
      .out_adj     (out_adj),
      .adj_err_cnt (adj_err_cnt)
   );

   always #5 clk = ~clk;

   // Record transfers that will happen on the coming rising edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            cap_gray.push_back(out_gray);
            cap_adj.push_back(out_adj);
         end
         if (in_valid && in_ready) sent_q.push_back(in_bin);
      end
   end

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input bit chk);
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid  = 1'($urandom);
         in_bin    = 4'($urandom);
         out_ready = 1'($urandom);
         tick();
         if (chk) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_in_ready", in_ready, 1);
            check("rst_cnt", adj_err_cnt, 0);
            check("rst_out_gray", out_gray, 0);
            check("rst_out_adj", out_adj, 0);
         end
      end
      cap_gray.delete();
      cap_adj.delete();
      sent_q.delete();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      rst_n     = 1'b1;
      tick();
   endtask

   // Present one word until accepted, bounded.
   task automatic send(input logic [3:0] b);
      int t = 0;
      in_valid = 1'b1;
      in_bin   = b;
      while (!in_ready && t < 50) begin
         tick();
         t++;
      end
      if (t >= 50) check("send_timeout", 0, 1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) tick();
   endtask

   task automatic run_vectors(input int lo, input int hi, input int exp_cnt);
      int n;
      do_reset(0);
      for (int i = lo; i <= hi; i++) send(vecs[i].bin);
      drain();
      n = hi - lo + 1;
      check("vec_count", cap_gray.size(), n);
      for (int k = 0; k < n && k < cap_gray.size(); k++) begin
         check($sformatf("vec%0d_gray", lo + k), cap_gray[k], vecs[lo + k].gray);
         check($sformatf("vec%0d_adj", lo + k), cap_adj[k], vecs[lo + k].adj);
      end
      check("vec_err_cnt", adj_err_cnt, exp_cnt);
   endtask

   initial begin
      logic [3:0] bp_words[3];
      logic [3:0] exp_g;
      logic [3:0] prev_g;
      int idx;
      int cyc;
      int exp_err;

      vecs[0]  = '{4'b0000, 4'b0000, 1'b0};
      vecs[1]  = '{4'b0001, 4'b0001, 1'b1};
      vecs[2]  = '{4'b0010, 4'b0011, 1'b1};
      vecs[3]  = '{4'b0011, 4'b0010, 1'b1};
      vecs[4]  = '{4'b0100, 4'b0110, 1'b1};
      vecs[5]  = '{4'b0101, 4'b0111, 1'b1};
      vecs[6]  = '{4'b0110, 4'b0101, 1'b1};
      vecs[7]  = '{4'b0111, 4'b0100, 1'b1};
      vecs[8]  = '{4'b1000, 4'b1100, 1'b1};
      vecs[9]  = '{4'b1001, 4'b1101, 1'b1};
      vecs[10] = '{4'b1010, 4'b1111, 1'b1};
      vecs[11] = '{4'b1011, 4'b1110, 1'b1};
      vecs[12] = '{4'b1100, 4'b1010, 1'b1};
      vecs[13] = '{4'b1101, 4'b1011, 1'b1};
      vecs[14] = '{4'b1110, 4'b1001, 1'b1};
      vecs[15] = '{4'b1111, 4'b1000, 1'b1};
      vecs[16] = '{4'b0000, 4'b0000, 1'b1};
      vecs[17] = '{4'b0111, 4'b0100, 1'b0};
      vecs[18] = '{4'b1001, 4'b1101, 1'b0};

      // Reset state, then latency of a single word
      do_reset(1);
      in_valid = 1'b1;
      in_bin   = 4'b0011;
      tick();
      in_valid = 1'b0;
      check("lat_edge1_valid", out_valid, 0);
      tick();
      check("lat_edge2_valid", out_valid, 1);
      check("lat_gray", out_gray, 4'b0010);
      check("lat_adj", out_adj, 0);
      drain();
      check("lat_cnt", adj_err_cnt, 0);

      // Full sweep with wrap, then skipped value
      run_vectors(0, 16, 0);
      run_vectors(17, 18, 1);

      // Backpressure: out_ready low for 5 cycles
      do_reset(0);
      bp_words[0] = 4'b0001;
      bp_words[1] = 4'b0010;
      bp_words[2] = 4'b0011;
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 5; c++) begin
         in_valid = (idx < 3);
         in_bin   = bp_words[idx < 3 ? idx : 2];
         #1;
         if (c >= 2) begin
            check($sformatf("bp_in_ready_c%0d", c), in_ready, 0);
            check($sformatf("bp_hold_gray_c%0d", c), out_gray, 4'b0001);
         end
         if (in_valid && in_ready) idx++;
         tick();
      end
      check("bp_accepted", idx, 2);
      out_ready = 1'b1;
      cyc = 0;
      while (idx < 3 && cyc < 20) begin
         in_valid = 1'b1;
         in_bin   = bp_words[idx];
         #1;
         if (in_ready) idx++;
         tick();
         cyc++;
      end
      drain();
      check("bp_count", cap_gray.size(), 3);
      if (cap_gray.size() == 3) begin
         check("bp_out0", cap_gray[0], 4'b0001);
         check("bp_out1", cap_gray[1], 4'b0011);
         check("bp_out2", cap_gray[2], 4'b0010);
         check("bp_adj1", cap_adj[1], 1);
         check("bp_adj2", cap_adj[2], 1);
      end

      // Randomized valid/ready against a reference queue
      do_reset(0);
      cyc = 0;
      while (sent_q.size() < 1000 && cyc < 20000) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_bin    = 4'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         tick();
         cyc++;
      end
      check("rand_all_sent", int'(sent_q.size() >= 1000), 1);
      drain();
      check("rand_count", cap_gray.size(), sent_q.size());
      exp_err = 0;
      prev_g  = '0;
      for (int k = 0; k < sent_q.size() && k < cap_gray.size(); k++) begin
         exp_g = sent_q[k] ^ (sent_q[k] >> 1);
         check($sformatf("rand_gray%0d", k), cap_gray[k], exp_g);
         if (k > 0) begin
            check($sformatf("rand_adj%0d", k), cap_adj[k],
                  int'($countones(exp_g ^ prev_g) == 1));
            if ($countones(exp_g ^ prev_g) != 1 && exp_err < 255) exp_err++;
         end
         prev_g = exp_g;
      end
      check("rand_err_cnt", adj_err_cnt, exp_err);

      // Saturation with repeated identical words
      do_reset(0);
      for (int i = 0; i < 200; i++) send(4'b0101);
      drain();
      check("sat_cnt_199", adj_err_cnt, 199);
      for (int i = 0; i < 100; i++) send(4'b0101);
      drain();
      check("sat_count", cap_gray.size(), 300);
      idx = 0;
      foreach (cap_gray[k]) if (cap_gray[k] !== 4'b0111) idx++;
      check("sat_gray_bad", idx, 0);
      check("sat_cnt_255", adj_err_cnt, 255);
      repeat (3) tick();
      check("sat_cnt_hold", adj_err_cnt, 255);

      // Mid-stream reset with both stages full
      do_reset(0);
      send(4'b0110);
      send(4'b0110);
      drain();
      check("mid_pre_cnt", adj_err_cnt, 1);
      out_ready = 1'b0;
      send(4'b1010);
      send(4'b1011);
      #1;
      check("mid_full_valid", out_valid, 1);
      check("mid_full_in_ready", in_ready, 0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_cnt", adj_err_cnt, 0);
      check("mid_rst_in_ready", in_ready, 1);
      cap_gray.delete();
      cap_adj.delete();
      tick();
      out_ready = 1'b1;
      in_valid  = 1'b0;
      rst_n     = 1'b1;
      repeat (5) tick();
      check("mid_no_stale", cap_gray.size(), 0);
      send(4'b0011);
      drain();
      check("mid_after_count", cap_gray.size(), 1);
      if (cap_gray.size() == 1) begin
         check("mid_after_gray", cap_gray[0], 4'b0010);
         check("mid_after_adj", cap_adj[0], 0);
      end
      check("mid_after_cnt", adj_err_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
